// File: rtl/max_finder_seq.sv
// Frame-level max detector: consumes FRAME_LEN unsigned samples over a
// valid/ready handshake and reports the largest one plus its frame position.
// Ties keep the earliest position. The result is held until the consumer
// takes it, and no new sample is accepted while a result is pending.
module max_finder_seq #(
   parameter int WIDTH     = 4,
   parameter int FRAME_LEN = 8,
   parameter int IDX_W     = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_max,
   output logic [IDX_W-1:0] out_idx
);

   localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(FRAME_LEN - 1);

   // One-hot style encoding so that the two unused codes are detectable and
   // can be steered back to COLLECT.
   typedef enum logic [1:0] {
      COLLECT = 2'b01,
      HOLD    = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] max_q, max_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             valid_q, valid_d;
   logic             accept;

   // Ready depends only on the state register (and reset), never on in_valid.
   assign in_ready  = (state_q == COLLECT) && !rst;
   assign accept    = in_valid && in_ready;

   // The running max/index registers double as the result registers; their
   // value only matters while out_valid is high.
   assign out_valid = valid_q;
   assign out_max   = max_q;
   assign out_idx   = idx_q;

   // Next-state: running compare during COLLECT, hold-until-taken in HOLD.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      max_d   = max_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      case (state_q)
         COLLECT: begin
            if (accept) begin
               // First sample of a frame always seeds the running max; later
               // samples must be strictly larger to take over.
               if ((cnt_q == '0) || (in_data > max_q)) begin
                  max_d = in_data;
                  idx_d = cnt_q;
               end
               if (cnt_q == LAST_CNT) begin
                  state_d = HOLD;
                  valid_d = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + IDX_W'(1);
               end
            end
         end
         HOLD: begin
            if (valid_q && out_ready) begin
               state_d = COLLECT;
               valid_d = 1'b0;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = COLLECT;
            cnt_d   = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= COLLECT;
         cnt_q   <= '0;
         max_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         max_q   <= max_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
      end
   end

endmodule
